// File: rtl/ucount_pkg.sv
// Definitions shared by the cascaded up/down counter blocks and their compare stage:
// the state encoding, the count widths and a composite-count helper.
package ucount_pkg;

  localparam int CNT_W  = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_PEND  = 2'b10
  } state_t;

  function automatic logic [CNT_W-1:0] compose_cnt(input logic [BYTE_W-1:0] hi,
                                                   input logic [BYTE_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/ucount_cmp16_if.sv
// Interface for the ucount_cmp16 compare stage. The master side drives the configuration,
// the control strobes and the counter taps. The slave side is the compare stage itself.
interface ucount_cmp16_if #(
  parameter int OVF_W = 4
);
  import ucount_pkg::*;

  logic              _cfg_wr;
  logic [CNT_W-1:0]  cfg_val;
  logic              arm;
  logic              disarm;
  logic              ack;
  logic [BYTE_W-1:0] dcount_high;
  logic [BYTE_W-1:0] dcount_low;
  logic              overflow_high;
  logic              match_irq;
  logic [CNT_W-1:0]  cap_val;
  logic              cfg_err;
  logic [OVF_W-1:0]  ovf_cnt;
  logic [1:0]        state;

  modport master (
    output _cfg_wr, cfg_val, arm, disarm, ack, dcount_high, dcount_low, overflow_high,
    input  match_irq, cap_val, cfg_err, ovf_cnt, state
  );

  modport slave (
    input  _cfg_wr, cfg_val, arm, disarm, ack, dcount_high, dcount_low, overflow_high,
    output match_irq, cap_val, cfg_err, ovf_cnt, state
  );

endinterface

// File: rtl/ucount_edge_sat.sv
// Rising-edge detector feeding a saturating event counter. A level held high counts once.
module ucount_edge_sat #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         level,
  output logic [W-1:0] cnt
);

  logic         prev_q;
  logic [W-1:0] cnt_q;
  logic         rise;

  assign rise = level & ~prev_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= level;
      if (rise && (cnt_q != {W{1'b1}})) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ucount_cmp16.sv
// Threshold compare, capture and interrupt stage for the cascaded 16-bit counter.
// Define UCOUNT_CMP_AUTORELOAD_EN to make ack in PEND re-arm the stage instead of idling it.
module ucount_cmp16
  import ucount_pkg::*;
#(
  parameter int               OVF_W   = 4,
  parameter logic [CNT_W-1:0] THR_RST = 16'hFFFF
) (
  input logic          clk,
  input logic          _areset,
  ucount_cmp16_if.slave bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic [CNT_W-1:0] cap_q, cap_d;
  logic             cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0] cnt;
  logic             wr;
  logic             hit;
  logic [OVF_W-1:0] ovf_cnt;

  assign cnt = compose_cnt(bus.dcount_high, bus.dcount_low);
  assign wr  = ~bus._cfg_wr;
  assign hit = (cnt == thr_q);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    thr_d     = thr_q;
    cap_d     = cap_q;
    cfg_err_d = wr && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (wr)      thr_d   = bus.cfg_val;
        if (bus.arm) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        // A match outranks a disarm presented in the same cycle.
        if (hit) begin
          state_d = ST_PEND;
          cap_d   = cnt;
        end else if (bus.disarm) begin
          state_d = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (bus.ack) begin
`ifdef UCOUNT_CMP_AUTORELOAD_EN
          state_d = bus.disarm ? ST_IDLE : ST_ARMED;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge _areset) begin
    if (!_areset) begin
      state_q   <= ST_IDLE;
      thr_q     <= THR_RST;
      cap_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      thr_q     <= thr_d;
      cap_q     <= cap_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  ucount_edge_sat #(
    .W(OVF_W)
  ) u_ovf (
    .clk  (clk),
    .rst_n(_areset),
    .level(bus.overflow_high),
    .cnt  (ovf_cnt)
  );

  assign bus.match_irq = (state_q == ST_PEND);
  assign bus.cap_val   = cap_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.ovf_cnt   = ovf_cnt;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_ucount_cmp16.sv
// Self-checking bench for ucount_cmp16. It runs a directed vector table, hand-written
// overflow and reset sequences, and then random traffic checked against a behavioural model.
module tb_ucount_cmp16;

  localparam int OVF_W = 4;
`ifdef UCOUNT_CMP_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic areset_n;
  always #5 clk = ~clk;

  ucount_cmp16_if #(.OVF_W(OVF_W)) bus ();

  ucount_cmp16 #(
    .OVF_W  (OVF_W),
    .THR_RST(16'hFFFF)
  ) dut (
    .clk     (clk),
    ._areset (areset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wr_n, input logic [15:0] val, input logic a,
                       input logic d, input logic k, input logic [15:0] c, input logic o);
    bus._cfg_wr       = wr_n;
    bus.cfg_val       = val;
    bus.arm           = a;
    bus.disarm        = d;
    bus.ack           = k;
    bus.dcount_high   = c[15:8];
    bus.dcount_low    = c[7:0];
    bus.overflow_high = o;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic irq, input logic [15:0] cap,
                               input logic err, input logic [1:0] st, input int ovf);
    check({tag, "_irq"},   {31'd0, bus.match_irq}, {31'd0, irq});
    check({tag, "_cap"},   {16'd0, bus.cap_val},   {16'd0, cap});
    check({tag, "_err"},   {31'd0, bus.cfg_err},   {31'd0, err});
    check({tag, "_state"}, {30'd0, bus.state},     {30'd0, st});
    check({tag, "_ovf"},   {28'd0, bus.ovf_cnt},   ovf);
  endtask

  // Directed vectors: inputs applied before an edge, outputs expected just after it.
  typedef struct {
    logic        wr_n;
    logic [15:0] val;
    logic        arm;
    logic        disarm;
    logic        ack;
    logic [15:0] cnt;
    logic        irq;
    logic [15:0] cap;
    logic        err;
    logic [1:0]  st;
  } vec_t;

  function automatic vec_t mk(input int wr_n, input logic [15:0] val, input int a, input int d,
                              input int k, input logic [15:0] c, input int irq,
                              input logic [15:0] cap, input int err, input int st);
    vec_t r;
    r.wr_n = wr_n[0]; r.val = val; r.arm = a[0]; r.disarm = d[0]; r.ack = k[0];
    r.cnt = c; r.irq = irq[0]; r.cap = cap; r.err = err[0]; r.st = st[1:0];
    return r;
  endfunction

  // Behavioural reference: abstract state number 0=idle, 1=armed, 2=pending.
  int          m_st;
  logic [15:0] m_thr;
  logic [15:0] m_cap;
  bit          m_err;
  int          m_ovf;
  bit          m_prev;

  task automatic model_reset();
    m_st = 0; m_thr = 16'hFFFF; m_cap = 16'h0000; m_err = 1'b0; m_ovf = 0; m_prev = 1'b0;
  endtask

  task automatic model_clock(input logic wr_n, input logic [15:0] val, input logic a,
                             input logic d, input logic k, input logic [15:0] c, input logic o);
    bit err_next;
    err_next = !wr_n && (m_st != 0);
    if (o && !m_prev && m_ovf < (2 ** OVF_W) - 1) m_ovf = m_ovf + 1;
    m_prev = o;
    if (m_st == 0) begin
      if (!wr_n) m_thr = val;
      if (a) m_st = 1;
    end else if (m_st == 1) begin
      if (c == m_thr) begin
        m_st  = 2;
        m_cap = c;
      end else if (d) begin
        m_st = 0;
      end
    end else begin
      if (k) m_st = (AUTO && !d) ? 1 : 0;
    end
    m_err = err_next;
  endtask

  vec_t tbl[18];

  initial begin
    int ack_st;
    ack_st = AUTO ? 1 : 0;

    tbl[0]  = mk(0, 16'h0105, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0);
    tbl[1]  = mk(1, 16'h0000, 1, 0, 0, 16'h0103, 0, 16'h0000, 0, 1);
    tbl[2]  = mk(1, 16'h0000, 0, 0, 0, 16'h0103, 0, 16'h0000, 0, 1);
    tbl[3]  = mk(1, 16'h0000, 0, 0, 0, 16'h0104, 0, 16'h0000, 0, 1);
    tbl[4]  = mk(0, 16'h00AA, 0, 0, 0, 16'h0104, 0, 16'h0000, 1, 1);
    tbl[5]  = mk(1, 16'h0000, 0, 0, 0, 16'h00AA, 0, 16'h0000, 0, 1);
    tbl[6]  = mk(1, 16'h0000, 0, 0, 0, 16'h0105, 1, 16'h0105, 0, 2);
    tbl[7]  = mk(1, 16'h0000, 1, 1, 0, 16'h0106, 1, 16'h0105, 0, 2);
    tbl[8]  = mk(0, 16'h1234, 0, 0, 0, 16'h0106, 1, 16'h0105, 1, 2);
    tbl[9]  = mk(1, 16'h0000, 0, 0, 1, 16'h0106, 0, 16'h0105, 0, ack_st);
    tbl[10] = mk(1, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h0105, 0, 1);
    tbl[11] = mk(1, 16'h0000, 0, 1, 0, 16'h0105, 1, 16'h0105, 0, 2);
    tbl[12] = mk(1, 16'h0000, 0, 1, 1, 16'h0000, 0, 16'h0105, 0, 0);
    tbl[13] = mk(1, 16'h0000, 0, 0, 1, 16'h0105, 0, 16'h0105, 0, 0);
    tbl[14] = mk(0, 16'h0200, 1, 0, 0, 16'h0200, 0, 16'h0105, 0, 1);
    tbl[15] = mk(1, 16'h0000, 0, 0, 0, 16'h0200, 1, 16'h0200, 0, 2);
    tbl[16] = mk(1, 16'h0000, 0, 0, 1, 16'h0000, 0, 16'h0200, 0, ack_st);
    tbl[17] = mk(1, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0200, 0, 0);

    // Power-on reset.
    areset_n = 1'b0;
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    #12;
    check_outputs("reset", 1'b0, 16'h0000, 1'b0, 2'b00, 0);
    areset_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].wr_n, tbl[i].val, tbl[i].arm, tbl[i].disarm, tbl[i].ack, tbl[i].cnt, 1'b0);
      step();
      check_outputs($sformatf("vec%0d", i), tbl[i].irq, tbl[i].cap, tbl[i].err, tbl[i].st, 0);
    end

    // Overflow: 17 pulses, the sixth held for 3 cycles, counter saturates at all-ones.
    for (int i = 0; i < 17; i++) begin
      int hold;
      int exp_cnt;
      hold    = (i == 5) ? 3 : 1;
      exp_cnt = (i + 1 < 15) ? i + 1 : 15;
      drive(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      for (int h = 0; h < hold; h++) begin
        step();
        check($sformatf("ovf_pulse%0d_h%0d", i, h), {28'd0, bus.ovf_cnt}, exp_cnt);
      end
      drive(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      step();
    end
    check("ovf_saturated", {28'd0, bus.ovf_cnt}, 32'hF);

    // Enter PEND, then pull reset between clock edges.
    drive(1'b0, 16'h0042, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    step();
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0042, 1'b0);
    step();
    check("pend_before_reset", {30'd0, bus.state}, 32'd2);
    check("irq_before_reset",  {31'd0, bus.match_irq}, 32'd1);
    #3;
    areset_n = 1'b0;
    #1;
    check_outputs("async_reset", 1'b0, 16'h0000, 1'b0, 2'b00, 0);
    #2;
    areset_n = 1'b1;
    // The threshold must be back at its reset value: 0042 no longer matches, FFFF does.
    drive(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    step();
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0042, 1'b0);
    step();
    check("thr_reset_nomatch", {30'd0, bus.state}, 32'd1);
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0);
    step();
    check_outputs("thr_reset_match", 1'b1, 16'hFFFF, 1'b0, 2'b10, 0);

    // Random traffic against the reference model.
    #2;
    areset_n = 1'b0;
    #2;
    areset_n = 1'b1;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      logic        wr_n, a, d, k, o;
      logic [15:0] val, c;
      int          pick;
      wr_n = ($urandom_range(0, 7) != 0);
      val  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      a    = ($urandom_range(0, 3) == 0);
      d    = ($urandom_range(0, 7) == 0);
      k    = ($urandom_range(0, 3) == 0);
      o    = ($urandom_range(0, 2) == 0);
      pick = $urandom_range(0, 3);
      if (pick == 0)      c = m_thr;
      else if (pick == 1) c = 16'($urandom_range(0, 15));
      else                c = 16'($urandom);
      drive(wr_n, val, a, d, k, c, o);
      model_clock(wr_n, val, a, d, k, c, o);
      step();
      check_outputs($sformatf("rnd%0d", n), (m_st == 2), m_cap, m_err, m_st[1:0], m_ovf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
